// File: rtl/rs232_receive_fifo.sv
// rs232_receive_fifo: RS232 8N1 receiver feeding a valid/ready FIFO, with CTS flow control.
// Define RS232_RX_FRAME_ERROR_EN to add the frame_error pulse output.
module rs232_receive_fifo #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DEPTH      = 4,
  parameter int CTS_MARGIN = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rs232_txd,
  output logic       rs232_ctsn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overrun
`ifdef RS232_RX_FRAME_ERROR_EN
  ,output logic      frame_error
`endif
);
  function automatic longint t_at(input int n);
    return (longint'(CLOCK_FREQ) * longint'(2 * n + 1) + longint'(BAUD_RATE)) /
           (longint'(2) * longint'(BAUD_RATE)) - longint'(1);
  endfunction
  localparam int T9 = int'(t_at(9));
  localparam int TW = $clog2(T9 + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CTS_LIM = (AW+1)'(DEPTH - CTS_MARGIN);
  // Mid-bit sample points, counted from the first low txd_f cycle
  localparam logic [TW-1:0] TS [10] = '{TW'(t_at(0)), TW'(t_at(1)), TW'(t_at(2)), TW'(t_at(3)),
    TW'(t_at(4)), TW'(t_at(5)), TW'(t_at(6)), TW'(t_at(7)), TW'(t_at(8)), TW'(t_at(9))};
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, txd_f, sample, push, shift, idle_next;
  logic [2:0] f_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] n_q, n_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic pop, full, acc;
  assign txd_f  = (f_q[0] & f_q[1]) | (f_q[0] & f_q[2]) | (f_q[1] & f_q[2]);
  assign sample = timer_q == TS[n_q];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      f_q  <= '1;
    end else begin
      s1_q <= rs232_txd;
      s2_q <= s1_q;
      f_q  <= {f_q[1:0], s2_q};
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = txd_f ? IDLE : START;
      START:      state_d = !sample ? START : txd_f ? IDLE : DATA;
      DATA:       state_d = (sample && n_q == 4'd8) ? STOP : DATA;
      STOP:       state_d = !sample ? STOP : txd_f ? IDLE : BREAK_WAIT;
      BREAK_WAIT: state_d = txd_f ? IDLE : BREAK_WAIT;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    push  = state_q == STOP && sample && txd_f;
    shift = state_q == DATA && sample;
  end
  always_comb begin
    idle_next = state_d == IDLE || state_d == BREAK_WAIT;
    timer_d   = idle_next ? '0 : timer_q + 1'b1;
    n_d       = idle_next ? '0 : n_q + 4'(sample);
    sh_d      = shift ? {txd_f, sh_q[7:1]} : sh_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      n_q     <= '0;
      sh_q    <= '0;
    end else begin
      timer_q <= timer_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
    end
  end
  // A push into a full FIFO only lands when the head is popped the same cycle
  always_comb begin
    pop   = valid && ready;
    full  = cnt_q == (AW+1)'(DEPTH);
    acc   = push && (!full || pop);
    cnt_d = cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
  end
  always_ff @(posedge clock) begin
    if (acc) mem_q[wp_q] <= sh_q;
  end
  assign data = mem_q[rp_q];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      valid      <= 1'b0;
      rs232_ctsn <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      wp_q       <= wp_q + AW'(acc);
      rp_q       <= rp_q + AW'(pop);
      cnt_q      <= cnt_d;
      valid      <= cnt_d != '0;
      rs232_ctsn <= cnt_d >= CTS_LIM;
      overrun    <= push && full && !pop;
    end
  end
`ifdef RS232_RX_FRAME_ERROR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) frame_error <= 1'b0;
    else frame_error <= state_q == STOP && sample && !txd_f;
  end
`endif
endmodule

// File: tb/tb_rs232_receive_fifo.sv
// tb_rs232_receive_fifo: directed and random frames against a queue-level model of the receiver.
module tb_rs232_receive_fifo;
  localparam int DEPTH = 4;
  localparam int MARGIN = 2;
  logic clock = 1'b0, resetn = 1'b0, txd = 1'b1, ready = 1'b1;
  logic ctsn, valid, overrun;
  logic [7:0] data;
  int checks = 0, errors = 0;
  int vcnt = 0, ovr_cnt = 0, cts_hi = 0, exp_ovr = 0;
  logic [7:0] got[$], exp_out[$], mq[$];
  logic [7:0] b;
  logic st;
`ifdef RS232_RX_FRAME_ERROR_EN
  logic frame_error;
  int ferr_cnt = 0, exp_ferr = 0;
`endif

  rs232_receive_fifo #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DEPTH(DEPTH), .CTS_MARGIN(MARGIN)) dut (
    .clock(clock), .resetn(resetn), .rs232_txd(txd), .rs232_ctsn(ctsn), .data(data),
    .valid(valid), .ready(ready), .overrun(overrun)
`ifdef RS232_RX_FRAME_ERROR_EN
    , .frame_error(frame_error)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (resetn) begin
    if (valid) vcnt++;
    if (valid && ready) got.push_back(data);
    if (overrun) ovr_cnt++;
    if (ctsn) cts_hi++;
`ifdef RS232_RX_FRAME_ERROR_EN
    if (frame_error) ferr_cnt++;
`endif
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A good frame is delivered at once when ready, queued up to DEPTH otherwise, else overruns
  task automatic model(input logic [7:0] v, input logic stop);
    if (!stop) begin
`ifdef RS232_RX_FRAME_ERROR_EN
      exp_ferr++;
`endif
    end else if (ready) exp_out.push_back(v);
    else if (mq.size() < DEPTH) mq.push_back(v);
    else exp_ovr++;
  endtask

  task automatic set_ready(input logic r);
    ready = r;
    if (r) while (mq.size() > 0) exp_out.push_back(mq.pop_front());
  endtask

  function automatic logic exp_cts();
    return (DEPTH - mq.size()) <= MARGIN;
  endfunction

  task automatic send(input logic [7:0] v, input logic stop);
    txd = 1'b0;
    cyc(10);
    for (int i = 0; i < 8; i++) begin
      txd = v[i];
      cyc(10);
    end
    txd = stop;
    cyc(10);
    model(v, stop);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, got.size(), exp_out.size());
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) chk(tag, got[i], exp_out[i]);
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ctsn", ctsn, 1);
    resetn = 1'b1;
    cyc(5);
    chk("idle_ctsn", ctsn, 0);
    vcnt = 0;
    cts_hi = 0;
    send(8'hA5, 1'b1);
    cyc(10);
    chk("t1_valid_cycles", vcnt, 1);
    check_out("t1_data");
    chk("t1_overrun", ovr_cnt, 0);
    chk("t1_ctsn_high_cycles", cts_hi, 0);
    txd = 1'b0;
    cyc(3);
    txd = 1'b1;
    cyc(30);
    check_out("t2_false_start");
    send(8'h3C, 1'b1);
    cyc(10);
    check_out("t2_data");
    send(8'h00, 1'b0);
    cyc(50);
    txd = 1'b1;
    cyc(20);
    check_out("t3_no_push");
`ifdef RS232_RX_FRAME_ERROR_EN
    chk("t3_frame_error", ferr_cnt, exp_ferr);
`endif
    send(8'h81, 1'b1);
    cyc(10);
    check_out("t3_data");
    set_ready(1'b0);
    for (int k = 1; k <= 4; k++) begin
      send(8'(k), 1'b1);
      cyc(5);
      chk("t4_ctsn", ctsn, exp_cts());
      chk("t4_valid", valid, 1);
      chk("t4_head", data, mq[0]);
    end
    send(8'h05, 1'b1);
    cyc(5);
    chk("t4_overrun", ovr_cnt, exp_ovr);
    chk("t4_head_after_ovr", data, mq[0]);
    set_ready(1'b1);
    cyc(10);
    check_out("t4_drain");
    chk("t4_ctsn_after", ctsn, 0);
    chk("t4_valid_after", valid, 0);
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    cyc(10);
    check_out("t5_b2b");
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      st = $urandom_range(0, 3) != 0;
      send(b, st);
      if (!st) begin
        txd = 1'b1;
        cyc(10);
      end else cyc($urandom_range(0, 12));
    end
    cyc(10);
    check_out("rnd");
    chk("rnd_overrun", ovr_cnt, exp_ovr);
`ifdef RS232_RX_FRAME_ERROR_EN
    chk("rnd_frame_error", ferr_cnt, exp_ferr);
`endif
    set_ready(1'b0);
    send(8'($urandom), 1'b1);
    send(8'($urandom), 1'b1);
    cyc(5);
    chk("t6_queued_valid", valid, 1);
    b = 8'($urandom);
    txd = 1'b0;
    cyc(10);
    for (int i = 0; i < 4; i++) begin
      txd = b[i];
      cyc(10);
    end
    txd = b[4];
    cyc(5);
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_ctsn", ctsn, 1);
    chk("t6_rst_overrun", overrun, 0);
    mq.delete();
    txd = 1'b1;
    cyc(3);
    resetn = 1'b1;
    cyc(20);
    set_ready(1'b1);
    cyc(5);
    check_out("t6_no_stale");
    chk("t6_ctsn", ctsn, 0);
    send(8'h7E, 1'b1);
    cyc(10);
    check_out("t6_data");
    chk("final_overrun", ovr_cnt, exp_ovr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
